// File: rtl/uart_rx_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_word_packer
// Purpose  : 8N1 UART receiver that packs NUM_BYTES consecutive bytes into a
//            single wide word. It rejects start-bit glitches, detects framing
//            errors and flushes a partial word after an inter-byte timeout.
//            The completed word is offered on a valid/ready output with
//            overrun reporting.
// Ports    : clk         - system clock
//            rst_n       - asynchronous active-low reset
//            en_rx       - receive enable (low aborts frame and partial word)
//            u_rx        - serial line, idle high (asynchronous to clk)
//            data_out    - packed word, first received byte in the MSBs
//            data_valid  - data_out holds an unconsumed word
//            data_ready  - consumer accepts when data_valid && data_ready
//            byte_cnt    - number of bytes held in the partial word
//            frame_err   - 1-cycle pulse, stop bit sampled low
//            overrun     - 1-cycle pulse, completed word dropped
//            timeout_err - 1-cycle pulse, partial word flushed
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_word_packer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_BYTES    = 16,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en_rx,
    input  logic                               u_rx,
    output logic [8*NUM_BYTES-1:0]             data_out,
    output logic                               data_valid,
    input  logic                               data_ready,
    output logic [$clog2(NUM_BYTES+1)-1:0]     byte_cnt,
    output logic                               frame_err,
    output logic                               overrun,
    output logic                               timeout_err
);

    localparam int W     = 8 * NUM_BYTES;
    localparam int CNT_W = $clog2(NUM_BYTES + 1);
    localparam int CLK_W = $clog2(CLKS_PER_BIT);

    localparam logic [CLK_W-1:0] HALF_M1  = CLK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CLK_W-1:0] BIT_LAST = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and edge detector (all reset to line-idle level)
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q, rx_prev_q;
    logic rx_s;

    assign rx_s = sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= u_rx;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    // ------------------------------------------------------------------
    // Bit-level FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CLK_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             frame_err_q, frame_err_d;
    logic             start_det;
    logic             byte_accept;

    // A start needs a high-to-low transition; after a framing error with the
    // line stuck low there is no transition, so the line must first return
    // high before another frame can begin.
    assign start_det = en_rx & rx_prev_q & ~rx_s & (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        rx_byte_d   = rx_byte_q;
        frame_err_d = 1'b0;
        byte_accept = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_det) begin
                    state_d   = ST_START;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_START: begin
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d = '0;
                    // Line back high at mid start bit: treat as a glitch.
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_W'(1);
                end
            end
            ST_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    rx_byte_d = {rx_s, rx_byte_q[7:1]};   // LSB first
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_W'(1);
                end
            end
            ST_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    // Return to idle right at the stop sample so a following
                    // start edge half a bit later is not missed.
                    state_d   = ST_IDLE;
                    if (rx_s) begin
                        byte_accept = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!en_rx) begin
            state_d     = ST_IDLE;
            clk_cnt_d   = '0;
            bit_cnt_d   = '0;
            frame_err_d = 1'b0;
            byte_accept = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            rx_byte_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_byte_q   <= rx_byte_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Inter-byte timeout
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             timeout_hit;

    generate
        if (TIMEOUT_BITS > 0) begin : g_timeout
            localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
            localparam int IDLE_W    = $clog2(TO_CYCLES);
            localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TO_CYCLES - 1);

            logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
            logic              counting;

            assign counting    = en_rx && (state_q == ST_IDLE) && (byte_cnt_q != '0);
            assign timeout_hit = counting && (idle_cnt_q == IDLE_LAST);

            always_comb begin
                idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                if (!counting || start_det || timeout_hit) begin
                    idle_cnt_d = '0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    idle_cnt_q <= '0;
                end else begin
                    idle_cnt_q <= idle_cnt_d;
                end
            end
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Word packer. Only the NUM_BYTES-1 preceding bytes need storing; the
    // final byte is concatenated straight from the receive register.
    // ------------------------------------------------------------------
    logic [W-9:0] shift_q, shift_d;
    logic [W-1:0] new_word;
    logic         word_done;
    logic         timeout_err_q, timeout_err_d;

    assign new_word = {shift_q, rx_byte_q};

    always_comb begin
        shift_d       = shift_q;
        byte_cnt_d    = byte_cnt_q;
        word_done     = 1'b0;
        timeout_err_d = 1'b0;

        if (byte_accept) begin
            shift_d = new_word[W-9:0];
            if (byte_cnt_q == CNT_LAST) begin
                word_done  = 1'b1;
                byte_cnt_d = '0;
            end else begin
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end
        end

        if (timeout_hit) begin
            shift_d       = '0;
            byte_cnt_d    = '0;
            timeout_err_d = 1'b1;
        end

        if (!en_rx) begin
            shift_d    = '0;
            byte_cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Output stage with valid/ready handshake
    // ------------------------------------------------------------------
    logic [W-1:0] data_out_q, data_out_d;
    logic         data_valid_q, data_valid_d;
    logic         overrun_q, overrun_d;

    always_comb begin
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        overrun_d    = 1'b0;

        if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end

        if (word_done) begin
            // A word accepted in this same cycle frees the slot for the new one.
            if (!data_valid_q || data_ready) begin
                data_out_d   = new_word;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q       <= '0;
            byte_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            shift_q       <= shift_d;
            byte_cnt_q    <= byte_cnt_d;
            timeout_err_q <= timeout_err_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign byte_cnt    = byte_cnt_q;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire
